// File: rtl/de10_pkg.sv
//------------------------------------------------------------------------------
// Module   : de10_pkg
// Brief    : Shared constants for the DE10-Lite counter top: digit count and
//            active-low seven-segment patterns (DP off).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package de10_pkg;

   localparam int NDIG = 6;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/de10_seg7_decoder.sv
//------------------------------------------------------------------------------
// Module   : seg7_decoder
// Brief    : Combinational BCD to active-low seven-segment decoder; non-BCD
//            codes blank the digit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg7_decoder
   import de10_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [7:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_digit)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/de10_top.sv
//------------------------------------------------------------------------------
// Module   : de10_top
// Brief    : DE10-Lite board top: selectable-rate tick divider driving a
//            6-digit BCD up/down counter on HEX5..HEX0 with status on LEDR.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module de10_top
   import de10_pkg::*;
#(
   parameter int FAST_DIV = 1_000_000,
   parameter int SLOW_DIV = 10_000_000,
   parameter int DIV_W    = 24
) (
   input  logic       ADC_CLK_10,
   input  logic [1:0] KEY,
   input  logic [9:0] SW,
   output logic [9:0] LEDR,
   output logic [7:0] HEX0,
   output logic [7:0] HEX1,
   output logic [7:0] HEX2,
   output logic [7:0] HEX3,
   output logic [7:0] HEX4,
   output logic [7:0] HEX5
);

   localparam logic [DIV_W-1:0] c_fastMax = DIV_W'(FAST_DIV - 1);
   localparam logic [DIV_W-1:0] c_slowMax = DIV_W'(SLOW_DIV - 1);

   logic clk;
   logic rst;
   logic w_down;
   logic w_hold;
   logic w_unusedSw;

   assign clk        = ADC_CLK_10;
   assign rst        = ~KEY[0];
   assign w_down     = SW[0];
   assign w_hold     = SW[9];
   assign w_unusedSw = SW[1];

   logic                       r_rateSync1;
   logic                       r_rateSync2;
   logic                       r_heartbeat;
   logic [DIV_W-1:0]           r_div;
   logic [NDIG-1:0][3:0]       r_digit;

   logic [DIV_W-1:0]           w_limitMax;
   logic                       w_tick;
   logic [NDIG-1:0][3:0]       w_nextDigit;
   logic                       w_carry;
   logic [NDIG-1:0][7:0]       w_seg;

   // ">=" rather than "==" so a drop to a smaller limit forces an immediate tick
   assign w_limitMax = r_rateSync2 ? c_slowMax : c_fastMax;
   assign w_tick     = ~w_hold & (r_div >= w_limitMax);

   // Ripple carry/borrow through the digits, lowest first
   always_comb begin
      w_nextDigit = r_digit;
      w_carry     = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (w_carry) begin
            if (w_down) begin
               if (r_digit[i] == 4'd0 || r_digit[i] > 4'd9) begin
                  w_nextDigit[i] = 4'd9;
               end else begin
                  w_nextDigit[i] = r_digit[i] - 4'd1;
                  w_carry        = 1'b0;
               end
            end else begin
               if (r_digit[i] >= 4'd9) begin
                  w_nextDigit[i] = 4'd0;
               end else begin
                  w_nextDigit[i] = r_digit[i] + 4'd1;
                  w_carry        = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rateSync1 <= 1'b1;
         r_rateSync2 <= 1'b1;
         r_heartbeat <= 1'b0;
         r_div       <= '0;
         r_digit     <= '0;
      end else begin
         r_rateSync1 <= KEY[1];
         r_rateSync2 <= r_rateSync1;
         if (w_tick) begin
            r_div       <= '0;
            r_digit     <= w_nextDigit;
            r_heartbeat <= ~r_heartbeat;
         end else if (!w_hold) begin
            r_div <= r_div + 1'b1;
         end
      end
   end

   generate
      for (genvar g = 0; g < NDIG; g++) begin : g_seg
         seg7_decoder u_dec (
            .i_digit (r_digit[g]),
            .o_seg   (w_seg[g])
         );
      end
   endgenerate

   assign HEX0 = w_seg[0];
   assign HEX1 = w_seg[1];
   assign HEX2 = w_seg[2];
   assign HEX3 = w_seg[3];
   assign HEX4 = w_seg[4];
   assign HEX5 = w_seg[5];

   assign LEDR = {SW[9:2], r_heartbeat, r_rateSync2};

endmodule

`default_nettype wire

// File: tb/tb_de10_top.sv
//------------------------------------------------------------------------------
// Module   : tb_de10_top
// Brief    : Scoreboard bench for de10_top against an integer-count model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_de10_top;

   logic       clk;
   logic [1:0] KEY;
   logic [9:0] SW;
   logic [9:0] LEDR;
   logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   de10_top #(.FAST_DIV(2), .SLOW_DIV(4), .DIV_W(4)) dut (
      .ADC_CLK_10 (clk),
      .KEY        (KEY),
      .SW         (SW),
      .LEDR       (LEDR),
      .HEX0       (HEX0),
      .HEX1       (HEX1),
      .HEX2       (HEX2),
      .HEX3       (HEX3),
      .HEX4       (HEX4),
      .HEX5       (HEX5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] hex;
      logic [9:0]  ledr;
   } exp_t;

   exp_t       sbq[$];
   int         total = 0;
   int         bad   = 0;
   bit         started = 0;
   logic [7:0] segTab[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   int mDiv, mCnt;
   bit mS1, mS2, mHb;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [47:0] hexOf(int cnt);
      logic [47:0] h;
      int          v;
      v = cnt;
      for (int i = 0; i < 6; i++) begin
         h[i*8 +: 8] = segTab[v % 10];
         v = v / 10;
      end
      return h;
   endfunction

   function automatic logic [47:0] actHex();
      return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
   endfunction

   // Reference model: count is a plain integer modulo 10^6
   always @(posedge clk) begin
      exp_t e;
      int   limit;
      if (!KEY[0]) begin
         mDiv = 0; mCnt = 0; mS1 = 1; mS2 = 1; mHb = 0;
      end else begin
         limit = mS2 ? 4 : 2;
         if (!SW[9]) begin
            if (mDiv >= limit - 1) begin
               mDiv = 0;
               mCnt = SW[0] ? (mCnt + 999999) % 1000000 : (mCnt + 1) % 1000000;
               mHb  = ~mHb;
            end else begin
               mDiv = mDiv + 1;
            end
         end
         mS2 = mS1;
         mS1 = KEY[1];
      end
      e.hex  = hexOf(mCnt);
      e.ledr = {SW[9:2], mHb, mS2};
      sbq.push_back(e);
      started = 1;
   end

   always @(negedge clk) begin
      exp_t e;
      if (started) begin
         if (sbq.size() == 0) begin
            chk("sbEmpty", 64'd0, 64'd1);
         end else begin
            e = sbq.pop_front();
            chk("hex", 64'(actHex()), 64'(e.hex));
            chk("ledr", 64'(LEDR), 64'(e.ledr));
         end
      end
   end

   task automatic step(int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic resetPulse();
      KEY[0] = 1'b0;
      #1;
      chk("asyncHex", 64'(actHex()), 64'({6{8'hC0}}));
      chk("asyncLed", 64'(LEDR), 64'({SW[9:2], 2'b01}));
      step(1);
      KEY[0] = 1'b1;
   endtask

   initial begin
      KEY = 2'b00;
      SW  = 10'd0;
      step(1);
      chk("rstHex", 64'(actHex()), 64'({6{8'hC0}}));
      chk("rstLed", 64'(LEDR), 64'(10'b0000000001));
      step(3);

      // slow count: 40 clocks -> count 10
      KEY = 2'b11;
      step(40);
      chk("slow10", 64'(actHex()), 64'({{4{8'hC0}}, 8'hF9, 8'hC0}));

      // fast rate and rate toggling
      KEY[1] = 1'b0;
      step(20);
      KEY[1] = 1'b1;
      step(3);
      KEY[1] = 1'b0;
      step(10);
      KEY[1] = 1'b1;
      step(7);
      KEY[1] = 1'b0;
      step(6);

      // down wrap from zero
      resetPulse();
      SW[0] = 1'b1;
      step(12);

      // up wrap from 999999
      resetPulse();
      for (int i = 0; i < 20 && mCnt != 999999; i++) step(1);
      chk("pre999999", 64'(mCnt), 64'd999999);
      SW[0] = 1'b0;
      step(8);

      // hold then mid-count reset
      SW[9] = 1'b1;
      step(20);
      SW[9] = 1'b0;
      step(7);
      resetPulse();
      step(5);

      // randomized run
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0, 9) == 0)  KEY[1] = ~KEY[1];
         if ($urandom_range(0, 14) == 0) SW[0]  = ~SW[0];
         if ($urandom_range(0, 19) == 0) SW[9]  = ~SW[9];
         SW[8:1] = 8'($urandom);
         if ($urandom_range(0, 59) == 0) resetPulse();
         else step(1);
      end

      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/de10_top.md
Name: de10_top

Overview:
- Board-level top for the DE10-Lite lab project.
- Divides the 10 MHz ADC_CLK_10 into a count tick whose rate is selected by push-button KEY[1].
- Drives a 6-digit BCD up/down counter shown on HEX5..HEX0, with status on LEDR.
- Only module at the pin boundary; contains one seven-segment decoder sub-module, instantiated six times.

Parameters:
- FAST_DIV, 1_000_000: clock cycles per tick at fast rate (10 Hz at 10 MHz); must be ≥1.
- SLOW_DIV, 10_000_000: clock cycles per tick at slow rate (1 Hz); must be ≥1.
- DIV_W, 24: divider counter width; must hold max(FAST_DIV, SLOW_DIV)-1.

Ports:
- ADC_CLK_10  input  1  sole clock, rising edge.
- KEY  input  2  push buttons, low when pressed. KEY[0] is the reset button: the internal reset rst = ~KEY[0] is asynchronous and active-high. KEY[1] is the rate select.
- SW  input  10  slide switches. SW[0]=1 counts down, 0 counts up. SW[9]=1 holds (freezes divider and counter). SW[8:1] unused.
- LEDR  output  10  LEDR[0] = current rate (1 = slow); LEDR[1] = tick heartbeat (toggles each tick); LEDR[9:2] = SW[9:2] mirrored.
- HEX0..HEX5  output  8 each  active-low segments: bit0=a … bit6=g, bit7=DP. HEX0 is the least significant digit.

Behaviour:
- Reset (rst=1, async):
  - divider = 0; all six BCD digits = 0.
  - rate synchronizer flops = 1 (slow); heartbeat = 0.
  - Outputs during reset: every HEX = 8'hC0 ("0", DP off); LEDR[1:0] = 2'b01; LEDR[9:2] = SW[9:2].
- Rate select:
  - KEY[1] passes through a 2-flop synchronizer; the synced value is "slow".
  - KEY[1] low → FAST_DIV; high → SLOW_DIV. Level-sensitive, no edge detect.
  - Latency from pin change to new rate: 2 clocks.
- Divider:
  - Each clock with hold=0: if div ≥ LIMIT-1 (LIMIT = selected DIV), then div←0 and tick=1 for that cycle; else div←div+1.
  - Switching to a smaller limit while div is larger forces a tick on the next clock.
  - hold=1: div frozen, no ticks.
- Counter (on the same edge as the tick):
  - Up: BCD increment with per-digit carry; 999999 wraps to 000000.
  - Down: decrement with borrow; 000000 wraps to 999999.
  - Digits are always 0–9.
  - SW[0] and SW[9] are used unsynchronized (static switches).
- Heartbeat toggles on every tick.
- HEX outputs are combinational from the BCD registers: digit d → segment pattern.
  - Patterns: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90.
  - Any non-BCD value → FF (blank). DP is always 1.
- Reset asserted mid-count returns everything to the reset state immediately.
- After reset release, counting resumes from 0 on the next clock.

Decomposition:
- Shared package de10_pkg: segment constants SEG_0..SEG_9, SEG_BLANK; digit count NDIG=6.
- Sub-module seg7_decoder: 4-bit BCD in, 8-bit active-low segments out, purely combinational, 6 instances.
- Divider, synchronizer and BCD counter live in de10_top.

Test Plan:
- Reset: KEY=00, SW=0 → all HEX=C0, LEDR=0000000001; hold KEY[0]=0 for 3 clocks, values unchanged.
- Slow count (FAST_DIV=2, SLOW_DIV=4): KEY=11 after reset → tick every 4 clocks; after 40 clocks HEX0=C0 (0), HEX1=F9 (1), i.e. count 10; LEDR[1] toggled 10 times.
- Fast rate: KEY[1] 1→0 → LEDR[0]=0 two clocks later, then a tick every 2 clocks; force a 0→1 transition and back, confirm the rate switch and the forced tick when div ≥ new limit.
- Down/wrap: SW[0]=1 from reset, first tick → all digits 9 (HEX=90 ×6); next tick → 999998 (HEX0=80).
- Up wrap: preload 999999 via down count, then set SW[0]=0 and apply one tick → 000000; confirm carry across all 6 digits.
- Hold/mid reset: SW[9]=1 → count and LEDR[1] frozen for 20 clocks; then pulse KEY[0]=0 mid-count → asynchronous clear to 000000 before the next edge.
